ingress_port: RTL

INGRESS_PORT -- requirements
Module: ingress_port

---
 rtl/pkt_switch_pkg.sv | 22 ++
 rtl/ingress_port_chk.sv | 26 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/ingress_port.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pkt_switch_pkg.sv
// Shared switch constants, FIFO entry layout and ingress write-FSM type.
package pkt_switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int DATA_W    = 8;
  localparam int ENTRY_W   = DATA_W + PORT_W + 1;

  // Write-side framing: HEAD waits for the first word of a frame, BODY for the rest.
  typedef enum logic [0:0] {
    WR_HEAD = 1'b0,
    WR_BODY = 1'b1
  } wr_state_e;

  // One buffered word as stored in the ingress FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PORT_W-1:0] dest;
    logic              last;
  } entry_t;

endpackage

// File: rtl/ingress_port_chk.sv
// Runtime checks on the ingress port head interface and FIFO occupancy.
module ingress_port_chk
  import pkt_switch_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PORT_INDEX = 0,
  parameter int CNT_W      = 5
) (
  input logic              clk,
  input logic              reset_n,
  input logic              out_valid,
  input logic              pop,
  input logic [DATA_W-1:0] out_data,
  input logic [PORT_W-1:0] out_dest,
  input logic              out_last,
  input logic [CNT_W-1:0]  count
);

  a_port_index: assert property (@(posedge clk) (PORT_INDEX >= 0) && (PORT_INDEX < NUM_PORTS));

  a_count_range: assert property (@(posedge clk) disable iff (!reset_n) (int'(count) <= DEPTH));

  a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !pop) |=> (out_valid && $stable({out_data, out_dest, out_last})));

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head entry reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == {CW{1'b0}});
  assign count     = cnt_q;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ingress_port.sv
// Switch ingress: tags each frame word with the destination of its first word and buffers it.
module ingress_port
  import pkt_switch_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PORT_INDEX = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [PORT_W-1:0]    in_dest,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [PORT_W-1:0]    out_dest,
  output logic                 out_last,
  input  logic [NUM_PORTS-1:0] egress_ready,
  output logic [15:0]          frame_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wr_state_e         state_q, state_d;
  logic [PORT_W-1:0] cur_dest_q, cur_dest_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              push_s, pop_s, full_s, empty_s;
  logic [CNT_W-1:0]  count_s;
  entry_t            wr_entry_s, rd_entry_s;

  assign in_ready    = ~full_s;
  assign push_s      = in_valid & ~full_s;
  assign out_valid   = ~empty_s;
  assign out_data    = rd_entry_s.data;
  assign out_dest    = rd_entry_s.dest;
  assign out_last    = rd_entry_s.last;
  assign pop_s       = ~empty_s & egress_ready[rd_entry_s.dest];
  assign frame_count = frame_count_q;

  // Write FSM: latch destination on the head word, reuse it for the body words.
  always_comb begin
    state_d         = state_q;
    cur_dest_d      = cur_dest_q;
    wr_entry_s.data = in_data;
    wr_entry_s.dest = cur_dest_q;
    wr_entry_s.last = in_last;
    case (state_q)
      WR_HEAD: begin
        wr_entry_s.dest = in_dest;
        if (push_s) begin
          cur_dest_d = in_dest;
          state_d    = in_last ? WR_HEAD : WR_BODY;
        end else begin
          state_d = WR_HEAD;
        end
      end
      WR_BODY: begin
        if (push_s && in_last) begin
          state_d = WR_HEAD;
        end else begin
          state_d = WR_BODY;
        end
      end
      default: begin
        state_d = WR_HEAD;
      end
    endcase
  end

  // Count frames whose final word has left towards its egress.
  always_comb begin
    if (pop_s && rd_entry_s.last) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Control registers, cleared asynchronously so a reset drops any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WR_HEAD;
      cur_dest_q    <= {PORT_W{1'b0}};
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cur_dest_q    <= cur_dest_d;
      frame_count_q <= frame_count_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .wdata   (wr_entry_s),
    .pop     (pop_s),
    .rdata   (rd_entry_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  ingress_port_chk #(
    .DEPTH      (DEPTH),
    .PORT_INDEX (PORT_INDEX),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .out_valid (out_valid),
    .pop       (pop_s),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .count     (count_s)
  );

endmodule
